// File: rtl/obi_data_mem.sv
// OBI data-side memory slave: byte-enable RAM, programmable grant/response latency and an
// in-order response queue. Define OBI_MEM_RANDOM_STALL_EN to add LFSR-driven grant stalls.
module obi_data_mem #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RVALID_DELAY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int unsigned AW = (RVALID_DELAY > 1) ? $clog2(RVALID_DELAY) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [WW-1:0] GntWait    = WW'(GNT_DELAY);
    localparam logic [AW-1:0] AgeReady   = AW'(RVALID_DELAY - 1);
    localparam logic [CW-1:0] CntMax     = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PtrLast    = PW'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]   RangeBytes = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem          [DEPTH_WORDS];
    logic [31:0]   fifo_rdata_q [MAX_OUTSTANDING];
    logic          fifo_err_q   [MAX_OUTSTANDING];
    logic [AW-1:0] fifo_age_q   [MAX_OUTSTANDING];

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          stall;
    logic          accept;
    logic          pop;
    logic          in_range;
    logic [31:0]   offset;
    logic [31:0]   be_mask;
    logic [31:0]   resp_rdata;
    logic [IW-1:0] idx;

`ifdef OBI_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall       = 1'b0;
`endif

    // Both counters saturate at their threshold, so equality doubles as ">=".
    always_comb begin
        offset   = data_addr_i - BASE_ADDR;
        in_range = offset < RangeBytes;
        idx      = offset[IW+1:2];
        for (int k = 0; k < 4; k++) begin
            be_mask[8*k +: 8] = {8{data_be_i[k]}};
        end
        resp_rdata = (in_range && !data_we_i) ? (mem[idx] & be_mask) : 32'h0;

        data_gnt_o = data_req_i && !rst && !stall && (wait_cnt_q == GntWait)
                     && (count_q < CntMax);
        accept     = data_gnt_o;
        pop        = (count_q != '0) && (fifo_age_q[rd_ptr_q] == AgeReady);

        wait_cnt_d = wait_cnt_q;
        if (!data_req_i || accept) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != GntWait) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rvalid_q   <= pop;
            if (pop) begin
                rdata_q <= fifo_rdata_q[rd_ptr_q];
                err_q   <= fifo_err_q[rd_ptr_q];
            end
        end
    end

    // RAM and queue payload are not reset; occupancy lives in count_q.
    always_ff @(posedge clk) begin
        if (accept && in_range && data_we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (accept && (wr_ptr_q == PW'(i))) begin
                fifo_rdata_q[i] <= resp_rdata;
                fifo_err_q[i]   <= !in_range;
                fifo_age_q[i]   <= '0;
            end else if (fifo_age_q[i] != AgeReady) begin
                fifo_age_q[i] <= fifo_age_q[i] + 1'b1;
            end
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

endmodule

// File: tb/tb_obi_data_mem.sv
// Randomized scoreboard bench for obi_data_mem: a driver issues OBI transfers and queues the
// expected responses; a negedge monitor checks grant timing, response timing and data.
module tb_obi_data_mem;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned GD    = 2;
    localparam int unsigned RD    = 3;
    localparam int unsigned MO    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic [31:0] data_addr_i = 32'h0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    always #5 clk = ~clk;

    obi_data_mem #(
        .DEPTH_WORDS    (DEPTH),
        .BASE_ADDR      (BASE),
        .GNT_DELAY      (GD),
        .RVALID_DELAY   (RD),
        .MAX_OUTSTANDING(MO),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } resp_t;

    resp_t       sb[$];
    int unsigned retire[$];
    logic [31:0] ref_mem [DEPTH];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned waitc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word array addressed by (addr-BASE)/4.
    function automatic resp_t model(input logic [31:0] addr, input logic we,
                                    input logic [3:0] be, input logic [31:0] wdata);
        resp_t       r;
        logic [31:0] off;
        int unsigned w;
        off     = addr - BASE;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        r.due   = 0;
        if (off < DEPTH * 4) begin
            w = off / 4;
            for (int k = 0; k < 4; k++) begin
                if (we && be[k]) ref_mem[w][8*k +: 8] = wdata[8*k +: 8];
                if (!we && be[k]) r.rdata[8*k +: 8] = ref_mem[w][8*k +: 8];
            end
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    // Monitor: expected grant from req history and outstanding count; responses from sb.
    always @(negedge clk) begin
        logic exp_gnt;
        resp_t e;
        if (rst) begin
            check("gnt_in_reset", {31'h0, data_gnt_o}, 32'h0);
            check("rvalid_in_reset", {31'h0, data_rvalid_o}, 32'h0);
            check("rdata_in_reset", data_rdata_o, 32'h0);
            check("err_in_reset", {31'h0, data_err_o}, 32'h0);
            sb.delete();
            retire.delete();
            waitc      = 0;
            last_rdata = 32'h0;
            last_err   = 1'b0;
        end else begin
            while (retire.size() > 0 && retire[0] <= cyc) void'(retire.pop_front());
            exp_gnt = data_req_i && (waitc >= GD) && (retire.size() < MO);
            check("gnt", {31'h0, data_gnt_o}, {31'h0, exp_gnt});
            if (exp_gnt) begin
                retire.push_back(cyc + 1 + RD);
                waitc = 0;
            end else if (data_req_i) begin
                waitc++;
            end else begin
                waitc = 0;
            end

            if (data_rvalid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 expected none (cycle %0d)",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_time", cyc, e.due);
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_rvalid: got rvalid=0 expected 1 at cycle %0d", e.due);
            end
            check("rdata", data_rdata_o, last_rdata);
            check("err", {31'h0, data_err_o}, {31'h0, last_err});
        end
    end

    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata);
        int unsigned waited;
        resp_t r;
        waited       = 0;
        data_req_i   = 1'b1;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wdata;
        forever begin
            @(negedge clk);
            if (data_gnt_o) break;
            waited++;
            if (waited > 40) break;
        end
        if (data_gnt_o) begin
            r     = model(addr, we, be, wdata);
            r.due = cyc + 1 + RD;
            sb.push_back(r);
        end else begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout: got no gnt expected one within 40 cycles (addr %h)", addr);
        end
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        for (int w = 0; w < int'(DEPTH); w++) issue(BASE + 32'(w * 4), 1'b1, 4'hF, $urandom);

        issue(BASE + 32'h40, 1'b1, 4'hF, 32'hDEADBEEF);
        issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0);

        issue(BASE + 32'h10, 1'b1, 4'hF, 32'h11223344);
        issue(BASE + 32'h10, 1'b1, 4'b0101, 32'hAABBCCDD);
        issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h12, 1'b0, 4'b1001, 32'h0);

        issue(BASE, 1'b1, 4'hF, 32'hCAFEF00D);
        issue(BASE + DEPTH * 4, 1'b0, 4'hF, 32'h0);
        issue(BASE + DEPTH * 4, 1'b1, 4'hF, 32'hFFFFFFFF);
        issue(BASE - 32'h4, 1'b1, 4'hF, 32'h12345678);
        issue(BASE, 1'b0, 4'hF, 32'h0);
        issue(BASE + DEPTH * 4 - 4, 1'b0, 4'hF, 32'h0);
        idle(6);

        // Back-to-back reads beyond the queue depth.
        issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
        issue(BASE, 1'b0, 4'hF, 32'h0);
        idle(6);

        // Request withdrawn before grant, then re-issued.
        data_req_i  = 1'b1;
        data_addr_i = BASE + 32'h8;
        idle(1);
        data_req_i = 1'b0;
        idle(1);
        issue(BASE + 32'h8, 1'b0, 4'hF, 32'h0);
        idle(6);

        // Reset with two reads in flight.
        issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(8);
        issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0);

        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                data_req_i  = 1'b1;
                data_addr_i = $urandom;
                idle(1);
                data_req_i = 1'b0;
                idle(1);
            end
            case ($urandom_range(0, 7))
                0:       a = BASE + DEPTH * 4 + 32'($urandom_range(0, 255));
                1:       a = BASE - 32'($urandom_range(1, 64));
                default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            issue(a, 1'($urandom), 4'($urandom), $urandom);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
